// File: rtl/add_round_key_pkg.sv
//------------------------------------------------------------------------------
// Module   : add_round_key_pkg
// Purpose  : Shared constants and the elaboration-time width check for the
//            AES AddRoundKey stage.
// Contents : AES_BLOCK_W   - width of a full AES block (128)
//            AES_BYTE_W    - width of one AES byte lane (8)
//            DEFAULT_WIDTH - default state/key width of the stage
//            width_is_byte_aligned() - true when a width is a positive whole
//                                      number of byte lanes
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package add_round_key_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int DEFAULT_WIDTH = 8;

    function automatic bit width_is_byte_aligned(input int w);
        return (w > 0) && ((w % AES_BYTE_W) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rk_skid_buffer.sv
//------------------------------------------------------------------------------
// Module   : rk_skid_buffer
// Purpose  : Two-entry valid/ready skid buffer. A main register drives the
//            output; a skid register catches one extra word so that in_ready
//            can be a pure register output (no combinational path from
//            out_ready). Words leave in acceptance order.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            in_data   - word to store          in_valid  - in_data is valid
//            in_ready  - buffer can accept      out_data  - head word
//            out_valid - out_data is valid      out_ready - head is taken
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rk_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    // Registered ready: held low during reset, rises on the first edge after
    // reset releases, and otherwise mirrors "skid register empty".
    logic             r_ready;

    logic [WIDTH-1:0] w_main_data_n;
    logic             w_main_valid_n;
    logic [WIDTH-1:0] w_skid_data_n;
    logic             w_skid_valid_n;
    logic             w_accept;
    logic             w_xfer;

    assign w_accept = in_valid && r_ready;
    assign w_xfer   = r_main_valid && out_ready;

    always_comb begin
        w_main_data_n  = r_main_data;
        w_main_valid_n = r_main_valid;
        w_skid_data_n  = r_skid_data;
        w_skid_valid_n = r_skid_valid;

        // Head leaves: promote the skid word if there is one.
        if (w_xfer) begin
            if (r_skid_valid) begin
                w_main_data_n  = r_skid_data;
                w_skid_valid_n = 1'b0;
            end else begin
                w_main_valid_n = 1'b0;
            end
        end

        // New word lands in main when main is (or is becoming) free, else in
        // skid. Accept with a full skid cannot happen since r_ready is low.
        if (w_accept) begin
            if (!r_main_valid || (w_xfer && !r_skid_valid)) begin
                w_main_data_n  = in_data;
                w_main_valid_n = 1'b1;
            end else begin
                w_skid_data_n  = in_data;
                w_skid_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_main_data  <= w_main_data_n;
            r_main_valid <= w_main_valid_n;
            r_skid_data  <= w_skid_data_n;
            r_skid_valid <= w_skid_valid_n;
            r_ready      <= !w_skid_valid_n;
        end
    end

    assign in_ready  = r_ready;
    assign out_data  = r_main_data;
    assign out_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/add_round_key.sv
//------------------------------------------------------------------------------
// Module   : add_round_key
// Purpose  : AES AddRoundKey: state XOR round key. Provides a zero-latency
//            combinational result and a registered copy behind a 2-entry
//            valid/ready skid buffer for pipelined round logic.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            in1       - state word            in2       - round-key word
//            out       - in1 ^ in2 (combinational)
//            in_valid  - in1/in2 carry a transaction
//            in_ready  - stage can accept a transaction (registered)
//            out_q     - registered XOR result
//            out_valid - out_q is valid        out_ready - out_q is taken
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module add_round_key
    import add_round_key_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    input  logic             out_ready
);

    // AES operates on whole byte lanes; reject any other width at elaboration.
    if (!width_is_byte_aligned(WIDTH)) begin : g_width_check
        $error("add_round_key: WIDTH must be a positive multiple of 8");
    end

    logic [WIDTH-1:0] w_xor;

    assign w_xor = in1 ^ in2;
    assign out   = w_xor;

    rk_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (w_xor),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_add_round_key.sv
//------------------------------------------------------------------------------
// Module   : tb_add_round_key
// Purpose  : Self-checking bench for add_round_key (WIDTH 8 and 128).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_add_round_key;
    import add_round_key_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in1, in2, out, out_q;
    logic         in_valid, in_ready, out_valid, out_ready;

    logic [AES_BLOCK_W-1:0] b_in1, b_in2, b_out, b_out_q;
    logic                   b_in_ready, b_out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: ordered list of results held by the stage.
    logic [W-1:0] m_q[$];
    logic         m_ready;

    add_round_key #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready)
    );

    add_round_key #(.WIDTH(AES_BLOCK_W)) dut_blk (
        .clk(clk), .rst(rst), .in1(b_in1), .in2(b_in2), .out(b_out),
        .in_valid(1'b0), .in_ready(b_in_ready),
        .out_q(b_out_q), .out_valid(b_out_valid), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives inputs, advances one cycle,
    // updates the model and checks the registered outputs.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy);
        logic         acc, xf;
        logic [W-1:0] dummy;
        in_valid  = v;
        in1       = a;
        in2       = b;
        out_ready = ordy;
        @(posedge clk);
        acc = v && m_ready;
        xf  = (m_q.size() > 0) && ordy;
        if (xf) dummy = m_q.pop_front();
        if (acc) m_q.push_back(a ^ b);
        m_ready = (m_q.size() < 2);
        #1;
        check("out_valid", {127'd0, out_valid}, {127'd0, m_q.size() > 0});
        if (m_q.size() > 0) check("out_q", {120'd0, out_q}, {120'd0, m_q[0]});
        check("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
        if (!$isunknown({a, b})) check("out_comb", {120'd0, out}, {120'd0, a ^ b});
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } comb_vec_t;

    comb_vec_t cvec[5];
    logic [W-1:0] pipe_exp[3];

    initial begin
        cvec[0] = '{8'hCB, 8'h9B, 8'h50};
        cvec[1] = '{8'hA5, 8'h00, 8'hA5};
        cvec[2] = '{8'hA5, 8'hFF, 8'h5A};
        cvec[3] = '{8'h3C, 8'h3C, 8'h00};
        cvec[4] = '{8'h12, 8'h34, 8'h26};
        pipe_exp[0] = 8'h50; pipe_exp[1] = 8'h26; pipe_exp[2] = 8'hF0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
        b_in1 = '0; b_in2 = '0;
        m_ready = 1'b0;

        // Combinational path, while held in reset.
        for (int i = 0; i < 5; i++) begin
            in1 = cvec[i].a; in2 = cvec[i].b;
            #10;
            check($sformatf("comb[%0d]", i), {120'd0, out}, {120'd0, cvec[i].exp});
        end

        b_in1 = 128'h00112233445566778899AABBCCDDEEFF;
        b_in2 = 128'h000102030405060708090A0B0C0D0E0F;
        #10;
        check("comb128", b_out, 128'h00102030405060708090A0B0C0D0E0F0);

        // Reset state.
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_q", {120'd0, out_q}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_blk_out_q", b_out_q, 128'd0);

        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 8'h00, 1'b1);
        check("ready_after_rst", {127'd0, in_ready}, 128'd1);

        // Back-to-back with out_ready high.
        step(1'b1, 8'hCB, 8'h9B, 1'b1);
        check("pipe0", {120'd0, out_q}, {120'd0, pipe_exp[0]});
        step(1'b1, 8'h12, 8'h34, 1'b1);
        check("pipe1", {120'd0, out_q}, {120'd0, pipe_exp[1]});
        step(1'b1, 8'hFF, 8'h0F, 1'b1);
        check("pipe2", {120'd0, out_q}, {120'd0, pipe_exp[2]});
        check("pipe_ready", {127'd0, in_ready}, 128'd1);
        step(1'b0, 8'h00, 8'h00, 1'b1);

        // Backpressure: third offer is refused, then drain in order.
        step(1'b1, 8'h11, 8'h22, 1'b0);
        step(1'b1, 8'h33, 8'h44, 1'b0);
        check("bp_full", {127'd0, in_ready}, 128'd0);
        step(1'b1, 8'h55, 8'h66, 1'b0);
        check("bp_hold", {120'd0, out_q}, 128'h33);
        step(1'bx == 1'b1 ? 1'b0 : 1'b0, 8'hxx, 8'hxx, 1'b1);
        check("bp_second", {120'd0, out_q}, 128'h77);
        check("bp_ready_back", {127'd0, in_ready}, 128'd1);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        check("bp_empty", {127'd0, out_valid}, 128'd0);

        // Reset mid-stream with two entries held.
        step(1'b1, 8'hA0, 8'h0A, 1'b0);
        step(1'b1, 8'hB0, 8'h0B, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_q", {120'd0, out_q}, 128'd0);
        check("mid_rst_ready", {127'd0, in_ready}, 128'd0);
        m_q.delete();
        m_ready = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_hold_valid", {127'd0, out_valid}, 128'd0);
        check("rst_hold_ready", {127'd0, in_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'hxx, 8'hxx, 1'b1);

        // Randomized traffic against the model, including X data when idle.
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            if (v)
                step(1'b1, W'($urandom), W'($urandom), ($urandom_range(0, 2) != 0));
            else
                step(1'b0, 8'hxx, 8'hxx, ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
